// File: rtl/scan_pkg.sv
// Shared types and constants for the two-channel scan scheduler.
package scan_pkg;

    localparam int unsigned StateW = 3;
    localparam int unsigned NumCh  = 2;

    typedef enum logic [StateW-1:0] {
        StOff   = 3'd0,
        StPwrup = 3'd1,
        StReady = 3'd2,
        StScan  = 3'd3,
        StXwait = 3'd4,
        StXfer  = 3'd5,
        StFlush = 3'd6
    } ch_state_e;

endpackage

// File: rtl/scan_channel_fsm.sv
// One scanner channel: state register, power-up counter, pending-go latch and
// rising-edge detection of the peer channel's level80/level90 flags.
module scan_channel_fsm
    import scan_pkg::*;
#(
    parameter int unsigned PWR_CYCLES = 4
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_run,
    input  logic      i_start,
    input  logic      i_peer_l80,
    input  logic      i_peer_l90,
    input  logic      i_l100,
    input  logic      i_grant,
    input  logic      i_xfer_end,
    output ch_state_e o_state,
    output logic      o_power,
    output logic      o_scan,
    output logic      o_xwait,
    output logic      o_xfer,
    output logic      o_flush
);

    localparam int unsigned CntW = (PWR_CYCLES > 1) ? $clog2(PWR_CYCLES) : 1;

    ch_state_e       r_state;
    ch_state_e       w_state_d;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_d;
    logic            r_go;
    logic            w_go_d;
    logic            r_l80_prev;
    logic            r_l90_prev;

    logic w_l80_rise;
    logic w_l90_rise;
    logic w_wake;
    logic w_pwr_done;

    assign w_l80_rise = i_peer_l80 & ~r_l80_prev;
    assign w_l90_rise = i_peer_l90 & ~r_l90_prev;
    // i_start is only ever driven for channel 0, already qualified by the top level.
    assign w_wake     = i_start | (i_run & w_l80_rise);
    assign w_pwr_done = (r_cnt == CntW'(PWR_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StOff;
            r_cnt      <= '0;
            r_go       <= 1'b0;
            r_l80_prev <= 1'b0;
            r_l90_prev <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_go       <= w_go_d;
            r_l80_prev <= i_peer_l80;
            r_l90_prev <= i_peer_l90;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_go_d    = r_go;
        case (r_state)
            StOff: begin
                if (w_wake) begin
                    w_state_d = StPwrup;
                    w_cnt_d   = '0;
                    w_go_d    = i_start;
                end
            end
            StPwrup: begin
                if (w_pwr_done) begin
                    if (r_go | w_l90_rise) begin
                        w_state_d = StScan;
                        w_go_d    = 1'b0;
                    end else begin
                        w_state_d = StReady;
                    end
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                    w_go_d  = r_go | w_l90_rise;
                end
            end
            StReady: begin
                if (r_go | w_l90_rise) begin
                    w_state_d = StScan;
                    w_go_d    = 1'b0;
                end else if (!i_run) begin
                    w_state_d = StOff;
                end
            end
            StScan: begin
                if (i_l100) w_state_d = StXwait;
            end
            StXwait: begin
                if (i_grant) w_state_d = StXfer;
            end
            StXfer: begin
                if (i_xfer_end) w_state_d = StFlush;
            end
            StFlush: begin
                w_state_d = StOff;
                w_go_d    = 1'b0;
            end
            default: begin
                w_state_d = StOff;
                w_go_d    = 1'b0;
            end
        endcase
    end

    always_comb begin
        o_state = r_state;
        o_power = (r_state != StOff);
        o_scan  = (r_state == StScan);
        o_xwait = (r_state == StXwait);
        o_xfer  = (r_state == StXfer);
        o_flush = (r_state == StFlush);
    end

endmodule

// File: rtl/scan_scheduler.sv
// Two-channel scan sequencer: run flag, upload-link arbiter and XFER mux.
// Optional upload watchdog is built when SCAN_WATCHDOG_EN is defined.
module scan_scheduler
    import scan_pkg::*;
#(
    parameter int unsigned PWR_CYCLES = 4
`ifdef SCAN_WATCHDOG_EN
    ,
    parameter int unsigned XFER_TIMEOUT = 64
`endif
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic                    i_stop,
    input  logic [NumCh-1:0]        i_level80,
    input  logic [NumCh-1:0]        i_level90,
    input  logic [NumCh-1:0]        i_level100,
    input  logic                    i_xfer_done,
    output logic [NumCh-1:0]        o_power_en,
    output logic [NumCh-1:0]        o_scan_en,
    output logic                    o_xfer_active,
    output logic                    o_xfer_sel,
    output logic [NumCh-1:0]        o_flush,
    output logic [NumCh*StateW-1:0] o_ch_state,
    output logic                    o_xfer_err
);

    logic r_run;
    logic r_last;
    logic r_xfer_sel;

    ch_state_e        w_state [NumCh];
    logic [NumCh-1:0] w_power;
    logic [NumCh-1:0] w_scan;
    logic [NumCh-1:0] w_xwait;
    logic [NumCh-1:0] w_xfer;
    logic [NumCh-1:0] w_flush;
    logic [NumCh-1:0] w_grant;
    logic             w_link_busy;
    logic             w_start_ok;
    logic             w_xfer_end;

    // stop dominates a coincident start
    assign w_start_ok  = i_start & ~i_stop & ~|w_power;
    assign w_link_busy = |w_xfer;

    always_comb begin
        w_grant = '0;
        if (!w_link_busy) begin
            if (&w_xwait) begin
                w_grant = r_last ? 2'b01 : 2'b10;
            end else begin
                w_grant = w_xwait;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run      <= 1'b0;
            r_last     <= 1'b1;
            r_xfer_sel <= 1'b0;
        end else begin
            if (i_stop) begin
                r_run <= 1'b0;
            end else if (w_start_ok) begin
                r_run <= 1'b1;
            end
            if (|w_grant) begin
                r_last     <= w_grant[1];
                r_xfer_sel <= w_grant[1];
            end
        end
    end

`ifdef SCAN_WATCHDOG_EN
    localparam int unsigned WdW = (XFER_TIMEOUT > 1) ? $clog2(XFER_TIMEOUT) : 1;

    logic [WdW-1:0] r_wd_cnt;
    logic           r_xfer_err;
    logic           w_wd_expire;

    assign w_wd_expire = w_link_busy & ~i_xfer_done & (r_wd_cnt == WdW'(XFER_TIMEOUT - 1));

    // Link is always idle for at least one cycle between uploads, which re-arms the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wd_cnt   <= '0;
            r_xfer_err <= 1'b0;
        end else begin
            if (!w_link_busy) begin
                r_wd_cnt <= '0;
            end else if (!w_wd_expire) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (w_wd_expire) r_xfer_err <= 1'b1;
        end
    end

    assign w_xfer_end = i_xfer_done | w_wd_expire;
    assign o_xfer_err = r_xfer_err;
`else
    assign w_xfer_end = i_xfer_done;
    assign o_xfer_err = 1'b0;
`endif

    scan_channel_fsm #(
        .PWR_CYCLES (PWR_CYCLES)
    ) u_ch0 (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_run      (r_run),
        .i_start    (w_start_ok),
        .i_peer_l80 (i_level80[1]),
        .i_peer_l90 (i_level90[1]),
        .i_l100     (i_level100[0]),
        .i_grant    (w_grant[0]),
        .i_xfer_end (w_xfer_end),
        .o_state    (w_state[0]),
        .o_power    (w_power[0]),
        .o_scan     (w_scan[0]),
        .o_xwait    (w_xwait[0]),
        .o_xfer     (w_xfer[0]),
        .o_flush    (w_flush[0])
    );

    scan_channel_fsm #(
        .PWR_CYCLES (PWR_CYCLES)
    ) u_ch1 (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_run      (r_run),
        .i_start    (1'b0),
        .i_peer_l80 (i_level80[0]),
        .i_peer_l90 (i_level90[0]),
        .i_l100     (i_level100[1]),
        .i_grant    (w_grant[1]),
        .i_xfer_end (w_xfer_end),
        .o_state    (w_state[1]),
        .o_power    (w_power[1]),
        .o_scan     (w_scan[1]),
        .o_xwait    (w_xwait[1]),
        .o_xfer     (w_xfer[1]),
        .o_flush    (w_flush[1])
    );

    assign o_power_en    = w_power;
    assign o_scan_en     = w_scan;
    assign o_flush       = w_flush;
    assign o_xfer_active = w_link_busy;
    assign o_xfer_sel    = r_xfer_sel;
    assign o_ch_state    = {w_state[1], w_state[0]};

endmodule
